// File: rtl/osc_pkg.sv
// osc_pkg: shared types and constants for the multi-mode oscillator.
//   osc_mode_e  - waveform select encoding (SAW, TRIANGLE, SQUARE, SILENCE)
//   DUTY_W      - width of the square-wave duty control
//   osc_state_e - top-level sequencing states (RESET -> PRIME -> RUN)
package osc_pkg;

    typedef enum logic [1:0] {
        SAW      = 2'd0,
        TRIANGLE = 2'd1,
        SQUARE   = 2'd2,
        SILENCE  = 2'd3
    } osc_mode_e;

    localparam int DUTY_W = 8;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } osc_state_e;

endpackage

// File: rtl/osc_multi_wave_if.sv
// osc_multi_wave_if: control inputs and valid/ready sample stream of the
// oscillator, bundled so the voice path wires one port.
//   freq_i  - phase increment (tuning word)
//   mode_i  - waveform select (osc_mode_e encoding)
//   duty_i  - square duty, high fraction = duty_i/256
//   sync_i  - hard-sync request
//   ready_i - downstream accepts sample
//   data_o  - signed sample
//   valid_o - data_o valid
// Modports: master = driver of controls / sample consumer, slave = oscillator.
interface osc_multi_wave_if #(
    parameter int width_p       = 12,
    parameter int phase_width_p = 24
);
    import osc_pkg::*;

    logic [phase_width_p-1:0] freq_i;
    logic [1:0]               mode_i;
    logic [DUTY_W-1:0]        duty_i;
    logic                     sync_i;
    logic                     ready_i;
    logic [width_p-1:0]       data_o;
    logic                     valid_o;

    modport master (
        output freq_i, mode_i, duty_i, sync_i, ready_i,
        input  data_o, valid_o
    );

    modport slave (
        input  freq_i, mode_i, duty_i, sync_i, ready_i,
        output data_o, valid_o
    );

endinterface

// File: rtl/osc_wave_shaper.sv
// osc_wave_shaper: combinational map from accumulator phase to a signed
// sample for the selected waveform.
//   phase_i  - accumulator phase (phase_width_p bits, phase_width_p >= 8)
//   mode_i   - waveform select
//   duty_i   - square duty threshold against the top 8 phase bits
//   sample_o - signed two's complement sample (width_p bits)
module osc_wave_shaper
    import osc_pkg::*;
#(
    parameter int width_p       = 12,
    parameter int phase_width_p = 24
) (
    input  logic [phase_width_p-1:0] phase_i,
    input  osc_mode_e                mode_i,
    input  logic [DUTY_W-1:0]        duty_i,
    output logic [width_p-1:0]       sample_o
);

    localparam logic [width_p-1:0] MAX_POS = {1'b0, {(width_p-1){1'b1}}};
    localparam logic [width_p-1:0] MAX_NEG = ~MAX_POS + width_p'(1);

    logic [width_p-1:0] saw_v;
    logic [width_p-1:0] tri_v;
    logic               unused_phase;

    // Low phase bits only carry fractional precision for the accumulator.
    assign unused_phase = ^phase_i;

    always_comb begin
        // Offset-binary to two's complement is just an MSB flip.
        saw_v          = phase_i[phase_width_p-1 -: width_p];
        saw_v[width_p-1] = ~saw_v[width_p-1];

        // Fold the second half-period back down, giving a symmetric ramp.
        tri_v = phase_i[phase_width_p-2 -: width_p];
        if (phase_i[phase_width_p-1]) begin
            tri_v = ~tri_v;
        end
        tri_v[width_p-1] = ~tri_v[width_p-1];

        case (mode_i)
            SAW:      sample_o = saw_v;
            TRIANGLE: sample_o = tri_v;
            SQUARE:   sample_o = (phase_i[phase_width_p-1 -: DUTY_W] < duty_i) ? MAX_POS : MAX_NEG;
            default:  sample_o = '0;
        endcase
    end

endmodule

// File: rtl/osc_multi_wave.sv
// osc_multi_wave: runtime-tunable phase-accumulator oscillator producing
// saw / triangle / variable-duty square samples on a valid/ready stream.
// Tuning, mode and duty are only taken at a phase wrap (or sync), so a
// retune never cuts a period short.
//   clk_i   - sample-rate clock
//   reset_i - synchronous active-high reset
//   bus     - osc_multi_wave_if.slave (controls in, samples out)
// Build option: define OSC_HARD_SYNC_EN to honour sync_i (with a pending
// flag that holds a request until the next accepted sample); otherwise
// sync_i is ignored.
module osc_multi_wave
    import osc_pkg::*;
#(
    parameter int width_p       = 12,
    parameter int phase_width_p = 24
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    osc_multi_wave_if.slave      bus
);

    localparam int P = phase_width_p;

    osc_state_e         state_q, state_d;
    logic [P-1:0]       phase_q, phase_d;
    logic [P-1:0]       inc_q, inc_d;
    osc_mode_e          mode_q, mode_d;
    logic [DUTY_W-1:0]  duty_q, duty_d;
    logic [width_p-1:0] data_q, data_d;
    logic [width_p-1:0] shp_sample;

    logic               hs;
    logic               sync_eff;
    logic               load;
    logic [P:0]         sum;

    assign hs  = (state_q == ST_RUN) && bus.ready_i;
    assign sum = {1'b0, phase_q} + {1'b0, inc_q};

`ifdef OSC_HARD_SYNC_EN
    logic sync_pend_q, sync_pend_d;

    assign sync_eff = bus.sync_i | sync_pend_q;

    // Requests seen while the consumer stalls are held (and merged) until
    // the next accepted sample.
    always_comb begin
        sync_pend_d = 1'b0;
        if (state_q == ST_RUN) begin
            if (hs) begin
                sync_pend_d = 1'b0;
            end else begin
                sync_pend_d = sync_pend_q | bus.sync_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_pend_q <= 1'b0;
        end else begin
            sync_pend_q <= sync_pend_d;
        end
    end
`else
    logic unused_sync;

    assign sync_eff    = 1'b0;
    assign unused_sync = bus.sync_i;
`endif

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        inc_d   = inc_q;
        mode_d  = mode_q;
        duty_d  = duty_q;
        load    = 1'b0;

        case (state_q)
            ST_RESET: state_d = ST_PRIME;
            ST_PRIME: begin
                load    = 1'b1;
                phase_d = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (hs) begin
                    // Carry out of the accumulator marks the period boundary;
                    // a sync restarts the period and counts as one.
                    load    = sum[P] | sync_eff;
                    phase_d = sync_eff ? '0 : sum[P-1:0];
                end
            end
            default: state_d = ST_RESET;
        endcase

        if (load) begin
            inc_d  = bus.freq_i;
            mode_d = osc_mode_e'(bus.mode_i);
            duty_d = bus.duty_i;
        end
    end

    // Shaped from the next-state values so the first sample after a reload
    // already uses the new mode and duty.
    osc_wave_shaper #(
        .width_p       (width_p),
        .phase_width_p (phase_width_p)
    ) u_shaper (
        .phase_i  (phase_d),
        .mode_i   (mode_d),
        .duty_i   (duty_d),
        .sample_o (shp_sample)
    );

    assign data_d = ((state_q == ST_PRIME) || hs) ? shp_sample : data_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_RESET;
            phase_q <= '0;
            inc_q   <= '0;
            mode_q  <= SILENCE;
            duty_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            inc_q   <= inc_d;
            mode_q  <= mode_d;
            duty_q  <= duty_d;
            data_q  <= data_d;
        end
    end

    assign bus.data_o  = data_q;
    assign bus.valid_o = (state_q == ST_RUN);

endmodule

// File: tb/tb_osc_multi_wave.sv
// tb_osc_multi_wave: directed scenarios followed by randomized stimulus,
// every cycle compared against an integer reference model of the
// oscillator's behaviour (phase as a plain integer modulo 2^P, waveforms
// from arithmetic on the phase value).
module tb_osc_multi_wave;
    import osc_pkg::*;

    localparam int W = 4;
    localparam int P = 8;
`ifdef OSC_HARD_SYNC_EN
    localparam bit SYNC_EN = 1'b1;
`else
    localparam bit SYNC_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    osc_multi_wave_if #(.width_p(W), .phase_width_p(P)) bus ();

    osc_multi_wave #(.width_p(W), .phase_width_p(P)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: 0 = held in reset, 1 = priming, 2 = streaming.
    int m_st    = 0;
    int m_phase = 0;
    int m_inc   = 0;
    int m_mode  = 3;
    int m_duty  = 0;
    int m_data  = 0;
    bit m_pend  = 1'b0;
    bit m_acc   = 1'b0;
    int n_txn   = 0;

    function automatic int shape_ref(int ph, int md, int dt);
        int half = 1 << (W - 1);
        int x;
        case (md)
            0: return (ph >> (P - W)) - half;
            1: begin
                x = ph >> (P - W - 1);
                if (x < (1 << W)) return x - half;
                return ((1 << (W + 1)) - 1 - x) - half;
            end
            2: return ((ph >> (P - 8)) < dt) ? (half - 1) : -(half - 1);
            default: return 0;
        endcase
    endfunction

    task automatic chk(string tag, int got, int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int  fi  = int'(bus.freq_i);
        int  mi  = int'(bus.mode_i);
        int  di  = int'(bus.duty_i);
        bit  syn;
        int  total_ph;
        bit  wrapped;
        m_acc = 1'b0;
        if (reset) begin
            m_st = 0; m_phase = 0; m_inc = 0; m_mode = 3; m_duty = 0;
            m_data = 0; m_pend = 1'b0;
        end else if (m_st == 0) begin
            m_st = 1;
        end else if (m_st == 1) begin
            m_inc = fi; m_mode = mi; m_duty = di; m_phase = 0;
            m_data = shape_ref(0, mi, di);
            m_st = 2;
        end else if (bus.ready_i) begin
            m_acc    = 1'b1;
            syn      = SYNC_EN && (bus.sync_i || m_pend);
            total_ph = m_phase + m_inc;
            wrapped  = (total_ph >= (1 << P)) || syn;
            m_phase  = syn ? 0 : (total_ph % (1 << P));
            if (wrapped) begin
                m_inc = fi; m_mode = mi; m_duty = di;
            end
            m_data = shape_ref(m_phase, m_mode, m_duty);
            m_pend = 1'b0;
        end else if (SYNC_EN && bus.sync_i) begin
            m_pend = 1'b1;
        end
    endtask

    function automatic int cur();
        return $signed(bus.data_o);
    endfunction

    // One clock: advance the model with the inputs seen at the edge, then
    // compare both outputs shortly after the edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("model_valid", int'(bus.valid_o), int'(m_st == 2));
        chk("model_data", cur(), m_data);
        if (m_acc) begin
            n_txn++;
            $display("txn %0d: data=%0d mode=%0d inc=%0d", n_txn, cur(), m_mode, m_inc);
        end
    endtask

    task automatic set_in(int f, int m, int d, bit s, bit r);
        bus.freq_i  = f[P-1:0];
        bus.mode_i  = m[1:0];
        bus.duty_i  = d[7:0];
        bus.sync_i  = s;
        bus.ready_i = r;
    endtask

    // Reset, release, and check the two-cycle prime latency and first sample.
    task automatic do_prime(int f, int m, int d, int first);
        reset = 1'b1;
        set_in(f, m, d, 1'b0, 1'b1);
        tick();
        tick();
        chk("rst_data", cur(), 0);
        chk("rst_valid", int'(bus.valid_o), 0);
        reset = 1'b0;
        tick();
        chk("prime_valid", int'(bus.valid_o), 0);
        tick();
        chk("first_valid", int'(bus.valid_o), 1);
        chk("first_data", cur(), first);
    endtask

    int tri_tab [16] = '{-8, -6, -4, -2, 0, 2, 4, 6, 7, 5, 3, 1, -1, -3, -5, -7};

    initial begin
        int v;
        int c;
        set_in(0, 0, 0, 1'b0, 1'b0);

        // Saw ramp at one step per cycle, including the wrap back to -8.
        do_prime(16, SAW, 0, -8);
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("ramp", cur(), (k % 16) - 8);
        end

        // Backpressure holds the sample; the ramp resumes where it stopped.
        for (int k = 0; k < 3; k++) tick();
        v = cur();
        bus.ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("hold", cur(), v);
        end
        bus.ready_i = 1'b1;
        tick();
        chk("resume", cur(), v + 1);

        // Retune mid-period: the saw period completes, then 50% square at 2x.
        c = cur();
        set_in(32, SQUARE, 128, 1'b0, 1'b1);
        for (int e = c + 1; e <= 7; e++) begin
            tick();
            chk("retune_saw", cur(), e);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("retune_sq", cur(), (i < 4) ? 7 : -7);
        end

        // Triangle shape over one period and back to the start.
        do_prime(16, TRIANGLE, 0, -8);
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("triangle", cur(), tri_tab[i % 16]);
        end

        // Zero duty square stays low.
        do_prime(16, SQUARE, 0, -7);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("duty0", cur(), -7);
        end

        // Hard sync requested while stalled, twice; applied on next accept.
        do_prime(16, SAW, 0, -8);
        for (int k = 0; k < 5; k++) tick();
        set_in(48, SAW, 0, 1'b1, 1'b0);
        tick();
        tick();
        bus.sync_i = 1'b0;
        tick();
        chk("sync_held", cur(), -3);
        bus.ready_i = 1'b1;
        tick();
        chk("sync_first", cur(), SYNC_EN ? -8 : -2);
        tick();
        chk("sync_second", cur(), SYNC_EN ? -5 : -1);
        tick();
        chk("sync_third", cur(), SYNC_EN ? -2 : 0);

        // Reset asserted during an accepted sample.
        reset = 1'b1;
        tick();
        chk("midrst_valid", int'(bus.valid_o), 0);
        chk("midrst_data", cur(), 0);
        reset = 1'b0;
        set_in(16, SAW, 0, 1'b0, 1'b1);
        tick();
        chk("reprime_valid", int'(bus.valid_o), 0);
        tick();
        chk("reprime_data", cur(), -8);

        // Randomized stimulus against the model.
        for (int n = 0; n < 400; n++) begin
            set_in(($urandom % 20 == 0) ? 0 : int'($urandom_range(0, 255)),
                   int'($urandom % 4), int'($urandom % 256),
                   ($urandom % 16) == 0, ($urandom % 4) != 0);
            reset = ($urandom % 100) == 0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
